// File: rtl/tt_asiclab_pkg.sv
// ----------------------------------------------------------------------------
// tt_asiclab_pkg
// Shared constants and types for the nibble un-sum tile.
//   SUM_W / OP_W   : width of the sum operand / recovered operand
//   CNT_W          : width of the serial step counter
//   pin indices    : bit positions of handshake signals on uio_in / uio_out
//   UIO_OE_MASK    : fixed output-enable pattern for the bidirectional pins
//   state_t        : control FSM states
// ----------------------------------------------------------------------------
package tt_asiclab_pkg;

   localparam int SUM_W = 5;
   localparam int OP_W  = 4;
   localparam int CNT_W = 3;

   localparam int IN_VALID  = 0;
   localparam int IN_READY  = 1;
   localparam int OUT_VALID = 2;
   localparam int BUSY      = 3;
   localparam int OUT_ACK   = 4;

   localparam logic [7:0] UIO_OE_MASK = 8'b0000_1110;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GET_A = 2'd1,
      CALC  = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/asiclab_serial_sub.sv
// ----------------------------------------------------------------------------
// asiclab_serial_sub
// One-bit full subtractor with a registered borrow, used LSB-first to compute
// s - a one bit per clock.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronously clears the borrow before a new subtraction
//   en         : advances one bit step (borrow register takes b_out)
//   s_bit      : current minuend bit
//   a_bit      : current subtrahend bit
//   d_bit      : difference bit for this step (combinational)
//   b_out      : borrow out of this step (combinational)
// ----------------------------------------------------------------------------
module asiclab_serial_sub (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic s_bit,
   input  logic a_bit,
   output logic d_bit,
   output logic b_out
);

   logic borrow;

   assign d_bit = s_bit ^ a_bit ^ borrow;
   assign b_out = (~s_bit & a_bit) | (~(s_bit ^ a_bit) & borrow);

   // NOTE: reset is sampled on the clock edge only (synchronous), so rst_n
   // is deliberately absent from the sensitivity list.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register sees pre-edge values regardless of statement order.
         borrow <= 1'b0;
      end else if (clr) begin
         borrow <= 1'b0;
      end else if (en) begin
         borrow <= b_out;
      end
   end

endmodule

// File: rtl/tt_um_asiclab_nibble_unsum.sv
// ----------------------------------------------------------------------------
// tt_um_asiclab_nibble_unsum
// Recovers B = S - A from a 5-bit sum S and a 4-bit operand A delivered as two
// valid/ready beats, using a bit-serial subtractor (one bit per clock). The
// result B and a range flag are held on uo_out until the host acknowledges.
//   clk, rst_n : clock, synchronous active-low reset
//   ui_in      : beat data; S on [4:0] in the first beat, A on [3:0] in the second
//   uio_in     : [0]=in_valid, [4]=out_ack
//   uio_out    : [1]=in_ready, [2]=out_valid, [3]=busy, other bits 0
//   uio_oe     : constant 8'b0000_1110
//   uo_out     : [3:0]=B, [4]=flag (no valid 4-bit B: S<A or S-A>15), [7:5]=0
//   ena        : unused
// ----------------------------------------------------------------------------
module tt_um_asiclab_nibble_unsum
   import tt_asiclab_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   output logic [7:0] uo_out
);

   state_t             state;
   state_t             state_nxt;

   logic [SUM_W-1:0]   s_sh;     // minuend, shifted right one bit per step
   logic [SUM_W-1:0]   a_sh;     // subtrahend, shifted right one bit per step
   logic [OP_W-1:0]    d_sh;     // difference bits collected MSB-in
   logic [CNT_W-1:0]   cnt;      // serial step counter
   logic [OP_W:0]      res_q;    // {flag, B} presented on uo_out

   logic in_valid;
   logic out_ack;
   logic take_s;
   logic take_a;
   logic step;
   logic last_step;
   logic d_bit;
   logic b_out;

   assign in_valid  = uio_in[IN_VALID];
   assign out_ack   = uio_in[OUT_ACK];

   // Beats are only consumed in the two input states, so in_valid seen in
   // CALC/DONE falls through without effect.
   assign take_s    = in_valid && (state == IDLE);
   assign take_a    = in_valid && (state == GET_A);
   assign step      = (state == CALC);
   assign last_step = step && (cnt == CNT_W'(SUM_W - 1));

   // ------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: defaulting every output of a combinational block first keeps
      // unlisted paths from inferring latches.
      state_nxt = state;
      unique case (state)
         IDLE:    if (in_valid)  state_nxt = GET_A;
         GET_A:   if (in_valid)  state_nxt = CALC;
         CALC:    if (last_step) state_nxt = DONE;
         DONE:    if (out_ack)   state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Serial subtractor
   // ------------------------------------------------------------------
   asiclab_serial_sub u_sub (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (take_a),
      .en    (step),
      .s_bit (s_sh[0]),
      .a_bit (a_sh[0]),
      .d_bit (d_bit),
      .b_out (b_out)
   );

   // ------------------------------------------------------------------
   // Operand shift registers, counter and result register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s_sh  <= '0;
         a_sh  <= '0;
         d_sh  <= '0;
         cnt   <= '0;
         res_q <= '0;
      end else begin
         if (take_s) begin
            s_sh <= ui_in[SUM_W-1:0];
         end
         if (take_a) begin
            a_sh <= SUM_W'(ui_in[OP_W-1:0]);
            cnt  <= '0;
         end
         if (step) begin
            s_sh <= s_sh >> 1;
            a_sh <= a_sh >> 1;
            d_sh <= {d_bit, d_sh[OP_W-1:1]};
            cnt  <= cnt + CNT_W'(1);
            // On the last step d_sh already holds d[3:0]; the live bit is
            // d[4]. A final borrow means S<A, d[4] without borrow means S-A>15.
            if (last_step) begin
               res_q <= {b_out | d_bit, d_sh};
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Outputs: all registered or decoded from state, never from ui_in
   // ------------------------------------------------------------------
   always_comb begin
      uio_out            = '0;
      uio_out[IN_READY]  = (state == IDLE) || (state == GET_A);
      uio_out[OUT_VALID] = (state == DONE);
      uio_out[BUSY]      = (state == CALC);
   end

   assign uio_oe = UIO_OE_MASK;
   assign uo_out = {{(8 - OP_W - 1){1'b0}}, res_q};

   logic unused_ok;
   assign unused_ok = &{1'b0, ena, ui_in[7:SUM_W], uio_in[7:5], uio_in[3:1]};

endmodule
